// File: rtl/vend_pkg.sv
// ------------------------------------------------------------------
// vend_pkg : shared types and denomination table for the dispenser
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DENOM_RS5  = 2'd0,
    DENOM_RS2  = 2'd1,
    DENOM_RS1  = 2'd2,
    DENOM_NONE = 2'd3
  } denom_t;

  localparam logic [4:0] c_val_rs5 = 5'd5;
  localparam logic [4:0] c_val_rs2 = 5'd2;
  localparam logic [4:0] c_val_rs1 = 5'd1;

  function automatic logic [4:0] denom_value(input denom_t code);
    case (code)
      DENOM_RS5: denom_value = c_val_rs5;
      DENOM_RS2: denom_value = c_val_rs2;
      DENOM_RS1: denom_value = c_val_rs1;
      default:   denom_value = 5'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ack_timer.sv
// ------------------------------------------------------------------
// ack_timer : loadable down-counter flagging a missing hopper ack
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int c_cnt_w = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(ACK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  // Loading ACK_TIMEOUT-1 makes the ACK_TIMEOUT-th enabled cycle the expiry cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = c_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - c_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_en && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ------------------------------------------------------------------
// change_dispenser : greedy Rs5/Rs2/Rs1 coin payout controller
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module change_dispenser
  import vend_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [4:0] req_amount,
  output logic       req_ready,
  output logic [1:0] hopper_sel,
  output logic       hopper_eject,
  input  logic       hopper_ack,
  input  logic [2:0] hopper_empty,
  input  logic       fault_clr,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [4:0] remaining
);

  state_t     state_q, state_d;
  denom_t     sel_q, sel_d;
  logic [4:0] remaining_q, remaining_d;
  logic       done_q, done_d;
  denom_t     pick;
  logic [4:0] rem_after;
  logic       ack_expired;

  ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (state_q == ST_EJECT),
    .i_en      (state_q == ST_WAIT_ACK),
    .o_expired (ack_expired)
  );

  // Later assignments override earlier ones, so the largest usable coin wins.
  always_comb begin
    pick = DENOM_NONE;
    if (!hopper_empty[2] && (remaining_q >= c_val_rs1)) pick = DENOM_RS1;
    if (!hopper_empty[1] && (remaining_q >= c_val_rs2)) pick = DENOM_RS2;
    if (!hopper_empty[0] && (remaining_q >= c_val_rs5)) pick = DENOM_RS5;
  end

  assign rem_after = remaining_q - denom_value(sel_q);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          state_d     = (req_amount == 5'd0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick == DENOM_NONE) begin
          state_d = ST_FAULT;
        end else begin
          sel_d   = pick;
          state_d = ST_EJECT;
        end
      end
      ST_EJECT: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        // A late ack landing on the expiry cycle still counts.
        if (hopper_ack) begin
          remaining_d = rem_after;
          state_d     = (rem_after == 5'd0) ? ST_DONE : ST_SELECT;
        end else if (ack_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= DENOM_RS5;
      remaining_q <= 5'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign hopper_eject = (state_q == ST_EJECT);
  assign fault        = (state_q == ST_FAULT);
  assign hopper_sel   = sel_q;
  assign done         = done_q;
  assign remaining    = remaining_q;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ------------------------------------------------------------------
// tb_change_dispenser : directed and random payouts against a coin model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_change_dispenser;

  localparam int ACK_T = 15;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [4:0] req_amount;
  logic       req_ready;
  logic [1:0] hopper_sel;
  logic       hopper_eject;
  logic       hopper_ack;
  logic [2:0] hopper_empty;
  logic       fault_clr;
  logic       busy;
  logic       done;
  logic       fault;
  logic [4:0] remaining;

  int n_cmp = 0;
  int n_err = 0;

  int exp_q[$];
  int exp_rem;
  bit exp_fault;

  change_dispenser #(
    .ACK_TIMEOUT (ACK_T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .hopper_sel   (hopper_sel),
    .hopper_eject (hopper_eject),
    .hopper_ack   (hopper_ack),
    .hopper_empty (hopper_empty),
    .fault_clr    (fault_clr),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .remaining    (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int code2val(input logic [1:0] c);
    case (c)
      2'd0:    return 5;
      2'd1:    return 2;
      2'd2:    return 1;
      default: return 0;
    endcase
  endfunction

  // Reference: pay out the largest usable coin until nothing is owed or the
  // payout gets stuck; an ack later than the timeout strands the first coin.
  task automatic model(input int amount, input logic [2:0] empty, input int dly);
    int rem;
    int d;
    exp_q.delete();
    rem       = amount;
    exp_fault = 1'b0;
    while (rem > 0 && !exp_fault) begin
      d = 0;
      if (rem >= 5 && !empty[0])      d = 5;
      else if (rem >= 2 && !empty[1]) d = 2;
      else if (rem >= 1 && !empty[2]) d = 1;
      if (d == 0) begin
        exp_fault = 1'b1;
      end else begin
        exp_q.push_back(d);
        if (dly > ACK_T) exp_fault = 1'b1;
        else rem -= d;
      end
    end
    exp_rem = rem;
  endtask

  task automatic run_txn(input string tag, input int amount, input logic [2:0] empty, input int dly);
    int got[$];
    int cyc = 0, post = -1, ack_cnt = 0, n_done = 0;
    int done_cyc = -1, fault_cyc = -1, ej_cyc = -1;
    logic [1:0] last_code = 2'd0;
    bit ended = 1'b0;
    model(amount, empty, dly);
    hopper_empty = empty;
    @(negedge clk);
    check({tag, "/ready_before"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_amount = amount[4:0];
    while (!ended) begin
      @(negedge clk);
      cyc++;
      req_valid  = 1'b0;
      hopper_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          hopper_ack = 1'b1;
          check({tag, "/sel_hold"}, 32'(hopper_sel), 32'(last_code));
        end
      end
      if (hopper_eject) begin
        got.push_back(code2val(hopper_sel));
        last_code = hopper_sel;
        ej_cyc    = cyc;
        ack_cnt   = dly;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (fault && fault_cyc < 0) fault_cyc = cyc;
      if (post < 0 && (done_cyc >= 0 || fault_cyc >= 0) && ack_cnt == 0) post = 0;
      else if (post >= 0) post++;
      if (post >= 3) ended = 1'b1;
      if (cyc >= 600) begin
        check({tag, "/finish_in_budget"}, 32'(done_cyc >= 0 || fault_cyc >= 0), 32'd1);
        ended = 1'b1;
      end
    end
    hopper_ack = 1'b0;
    check({tag, "/coin_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check({tag, "/coin_value"}, 32'(got[i]), 32'(exp_q[i]));
    check({tag, "/done_pulses"}, 32'(n_done), exp_fault ? 32'd0 : 32'd1);
    check({tag, "/fault"}, 32'(fault), 32'(exp_fault));
    check({tag, "/remaining"}, 32'(remaining), 32'(exp_rem));
    check({tag, "/busy"}, 32'(busy), 32'(exp_fault));
    if (amount == 0) check({tag, "/done_latency"}, 32'(done_cyc), 32'd2);
    if (exp_fault && dly > ACK_T && got.size() > 0)
      check({tag, "/timeout_latency"}, 32'(fault_cyc - ej_cyc - 1), 32'(ACK_T));
    if (exp_fault) begin
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      @(negedge clk);
      check({tag, "/ready_after_clr"}, 32'(req_ready), 32'd1);
      check({tag, "/fault_after_clr"}, 32'(fault), 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/remaining"}, 32'(remaining), 32'd0);
    check({tag, "/sel"}, 32'(hopper_sel), 32'd0);
    check({tag, "/eject"}, 32'(hopper_eject), 32'd0);
    check({tag, "/done"}, 32'(done), 32'd0);
    check({tag, "/fault"}, 32'(fault), 32'd0);
  endtask

  task automatic reset_mid_op();
    int waited = 0;
    int ejects = 0;
    hopper_empty = 3'b000;
    @(negedge clk);
    req_valid  = 1'b1;
    req_amount = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    while (!hopper_eject && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid/eject_seen", 32'(hopper_eject), 32'd1);
    @(negedge clk);
    check("rst_mid/busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b1;
    fault_clr  = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    fault_clr  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (hopper_eject) ejects++;
    end
    check("rst_mid/stray_ejects", 32'(ejects), 32'd0);
    check_reset_values("rst_mid_after");
  endtask

  initial begin
    int amt;
    logic [2:0] emp;
    int dly;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_amount   = 5'd0;
    hopper_ack   = 1'b0;
    hopper_empty = 3'b000;
    fault_clr    = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_txn("amt8_full",       8,  3'b000, 2);
    run_txn("amt6_rs5_empty",  6,  3'b001, 2);
    run_txn("amt3_rs1_empty",  3,  3'b100, 2);
    run_txn("amt5_no_ack",     5,  3'b000, 100);
    run_txn("amt0",            0,  3'b000, 2);
    run_txn("ack_at_limit",    9,  3'b000, ACK_T);
    run_txn("ack_past_limit",  2,  3'b000, ACK_T + 1);
    run_txn("all_empty",       4,  3'b111, 1);
    run_txn("amt31",           31, 3'b000, 1);
    reset_mid_op();

    for (int i = 0; i < 25; i++) begin
      amt = int'($urandom_range(0, 31));
      emp = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(ACK_T, ACK_T + 1))
                                        : int'($urandom_range(1, 4));
      run_txn("random", amt, emp, dly);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
